toom3_gf2_scheduler: RTL
========================

# toom3_gf2_scheduler

Sequencer that computes a 12x13-bit carry-less (GF(2)[x]) product on a single shared 4x5-bit bit-serial multiply-accumulate engine. It splits the operands three ways and runs the nine partial products through the engine in a fixed order, accumulating each at its true bit offset. It accepts operands and returns the product over valid/ready handshakes. It is the area-reduced, time-multiplexed counterpart of the parallel three-way Toom-Cook multiplier.

## Interface
- No parameters. Widths are fixed: A 12 bits, B 13 bits, product 25 bits.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept operands; high only in IDLE.
- a  in  12  operand A, polynomial coefficients, bit i = x^i.
- b  in  13  operand B.
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  consumer accepts result.
- c  out  25  carry-less product. Bit 24 is always 0.
- busy  out  1  high in MUL.
- term_idx  out  4  index 0..8 of the partial product in progress. 0 outside MUL.

## Operation
- Split A into a0=a[3:0], a1=a[7:4], a2=a[11:8], at offsets oa = 0, 4, 8.
- Split B into b0=b[4:0], b1=b[8:5], b2=b[12:9], at offsets ob = 0, 5, 9.
- Fixed term order, indexed by term_idx: (a0,b0), (a0,b1), (a1,b0), (a0,b2), (a1,b1), (a2,b0), (a1,b2), (a2,b1), (a2,b2).
- FSM states: IDLE, MUL, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready:
  - latch a and b;
  - clear the 25-bit accumulator acc;
  - set term_idx=0 and bit counter k=0;
  - go to MUL.
- MUL, one engine step per cycle, for current term (ai, bj):
  - if ai[k]==1, acc <= acc ^ (bj << (oa_i + ob_j + k));
  - k increments 0..3;
  - at k==3, k wraps to 0 and term_idx increments.
- MUL exit: after term 8, k=3, load c <= final acc (including that step's XOR), assert out_valid, go to DONE.
- DONE:
  - out_valid=1 and c held stable;
  - on out_ready, drop out_valid and go to IDLE;
  - c keeps its value until the next DONE load.
- No zero-skipping. Latency is data-independent.
- Arithmetic is XOR only, with no carries. Shifted bj never exceeds bit 23; acc is 25 bits.
- in_valid is ignored outside IDLE. Latched operands are unaffected by input changes during MUL/DONE.
- in_ready=0 in DONE. An input offered in the same cycle that out_ready is accepted is taken the following cycle, in IDLE.

## Timing
- Cycle 0: input handshake at the clock edge.
- Cycles 1..36: MUL, 9 terms x 4 bits.
- Cycle 37: out_valid=1 with c valid. Minimum turnaround per operation is 38 cycles (37 + 1 IDLE).
- busy=1 exactly in cycles 1..36.
- term_idx=n during cycles 4n+1 .. 4n+4.
- Reset values: state IDLE, in_ready=1, out_valid=0, busy=0, c=0, term_idx=0, acc=0, k=0.
- Reset at any time (mid-MUL or in DONE) aborts the operation with no partial result. All outputs take reset values on the next cycle, and the latched operands are discarded.
- If out_ready is already high when DONE is entered, out_valid is high for exactly one cycle.

## Test plan
- a=12'h003, b=13'h0003, out_ready=1 -> out_valid rises 37 cycles after the handshake, c=25'h0000005.
- a=12'h800, b=13'h1000 (highest terms) -> c=25'h0800000. Bit 24 is 0.
- a=12'h111, b=13'h0201 (cross-segment offsets) -> c=25'h0022311. Check term_idx and busy sequence 0..8 over cycles 1..36.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid, then pulse in_valid during DONE -> c and out_valid stable, in_ready=0, new input accepted only once back in IDLE.
- Assert rst at cycle 20 of MUL -> next cycle: out_valid=0, c=0, in_ready=1, busy=0. A following a=12'h003, b=13'h0003 yields c=5.
- 1000 random (a,b) pairs with random out_ready/in_valid gaps -> c matches a software carry-less multiply, latency always 37.

Source files
------------

// File: rtl/toom3_gf2_scheduler.sv
// toom3_gf2_scheduler
//
// Time-multiplexed 12x13-bit carry-less (GF(2)[x]) multiplier. Operand A is
// split into three 4-bit segments at offsets 0/4/8 and operand B into
// 5/4/4-bit segments at offsets 0/5/9. The nine segment products are fed one
// bit of the A-segment per cycle through a single shift-and-XOR step, each
// contribution landing directly at its final bit position in a 25-bit
// accumulator.
//
// Handshakes (both ports): a transfer happens on a rising clk edge where
// valid and ready are both high. The producer holds valid and its payload
// stable until that edge. in_ready is a pure function of state (high only in
// IDLE). out_valid is held with c stable until out_ready is seen.
//
// Latency is fixed: handshake edge, 36 MUL cycles (9 terms x 4 bits), then
// the result is presented in DONE. There is no zero-skipping.

module toom3_gf2_scheduler (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [11:0] a,
    input  logic [12:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [24:0] c,
    output logic        busy,
    output logic [3:0]  term_idx
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;

    // Latched operands, captured on the input handshake.
    logic [11:0] a_q;
    logic [12:0] b_q;

    // Running product and the registered result.
    logic [24:0] acc;
    logic [24:0] acc_nxt;
    logic [24:0] c_q;

    // Bit position inside the current A-segment and the term counter.
    logic [1:0]  k;
    logic [3:0]  idx;

    // Per-term operand selection.
    logic [1:0]  sel_a;
    logic [1:0]  sel_b;
    logic [3:0]  ai;
    logic [4:0]  bj;
    logic [3:0]  oa;
    logic [3:0]  ob;
    logic [4:0]  shamt;
    logic [24:0] step_term;
    logic        last_step;

    // Fixed term order: segment pairs sorted by i+j, so lower-order
    // contributions are accumulated first.
    always_comb begin
        sel_a = 2'd0;
        sel_b = 2'd0;
        case (idx)
            4'd0:    begin sel_a = 2'd0; sel_b = 2'd0; end
            4'd1:    begin sel_a = 2'd0; sel_b = 2'd1; end
            4'd2:    begin sel_a = 2'd1; sel_b = 2'd0; end
            4'd3:    begin sel_a = 2'd0; sel_b = 2'd2; end
            4'd4:    begin sel_a = 2'd1; sel_b = 2'd1; end
            4'd5:    begin sel_a = 2'd2; sel_b = 2'd0; end
            4'd6:    begin sel_a = 2'd1; sel_b = 2'd2; end
            4'd7:    begin sel_a = 2'd2; sel_b = 2'd1; end
            4'd8:    begin sel_a = 2'd2; sel_b = 2'd2; end
            default: begin sel_a = 2'd0; sel_b = 2'd0; end
        endcase
    end

    // Segment extraction and their bit offsets within the full operands.
    always_comb begin
        ai = 4'd0;
        oa = 4'd0;
        bj = 5'd0;
        ob = 4'd0;
        case (sel_a)
            2'd0:    begin ai = a_q[3:0];  oa = 4'd0; end
            2'd1:    begin ai = a_q[7:4];  oa = 4'd4; end
            default: begin ai = a_q[11:8]; oa = 4'd8; end
        endcase
        case (sel_b)
            2'd0:    begin bj = b_q[4:0];          ob = 4'd0; end
            2'd1:    begin bj = {1'b0, b_q[8:5]};  ob = 4'd5; end
            default: begin bj = {1'b0, b_q[12:9]}; ob = 4'd9; end
        endcase
    end

    // One engine step: XOR the shifted B-segment in when the selected
    // A-segment bit is set. The largest shift is 8+9+3=20 on a 4-bit
    // segment, so nothing reaches bit 24.
    always_comb begin
        shamt     = {1'b0, oa} + {1'b0, ob} + {3'b000, k};
        step_term = {20'd0, bj} << shamt;
        acc_nxt   = ai[k] ? (acc ^ step_term) : acc;
        last_step = (idx == 4'd8) && (k == 2'd3);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake/status outputs.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = MUL;
                end
            end
            MUL: begin
                busy = 1'b1;
                if (last_step) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath: operand capture, accumulation, counters and result load.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q <= 12'd0;
            b_q <= 13'd0;
            acc <= 25'd0;
            c_q <= 25'd0;
            k   <= 2'd0;
            idx <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q <= a;
                        b_q <= b;
                        acc <= 25'd0;
                        k   <= 2'd0;
                        idx <= 4'd0;
                    end
                end
                MUL: begin
                    acc <= acc_nxt;
                    k   <= k + 2'd1;
                    if (k == 2'd3) begin
                        if (last_step) begin
                            c_q <= acc_nxt;
                            idx <= 4'd0;
                        end else begin
                            idx <= idx + 4'd1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign c        = c_q;
    assign term_idx = idx;

endmodule
